operand_collector: RTL

Gathers two consecutive 16-bit data-memory words into an ALU operand pair, issues them with a command to the clocked ALU, and captures the result and flags into a holding register with valid/ready output. Sits between the data-ROM read port, downstream of obj_ref, and the alu instance. It replaces the free-running A/B toggle with a flow-controlled collector, so operand pairing survives stalls and flushes.

---
 rtl/operand_collector_pkg.sv | 17 +
 rtl/operand_collector.sv | 96 +++++++++
 2 files changed

// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg: shared definitions for the operand collector and its ALU.
// Holds the default data/command widths, the ALU command codes and the
// positions of the zero and carry bits inside the captured flag pair.
package operand_collector_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CMD_W = 3;
    localparam int Z_BIT = 1;
    localparam int CY_BIT = 0;
    localparam logic [2:0] ALU_NC = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_SL = 3'd6;
    localparam logic [2:0] ALU_SR = 3'd7;
endpackage

// File: rtl/operand_collector.sv
// operand_collector: pairs two consecutive data words into ALU operands and holds the result.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   flush                    drop any partial pair or pending result
//   in_valid/in_ready/in_data/in_cmd   word input; in_cmd taken with the second word
//   alu_a/alu_b/alu_cmd      registered operands and command to the ALU
//   alu_r/alu_z/alu_cy       ALU result and flags
//   out_valid/out_ready/out_result/out_flags   held result, flags = {z, cy}
//   busy                     collector is not empty
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CMD_W = DEF_CMD_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CMD_W-1:0]  in_cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_z,
    input  logic              alu_cy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [1:0]        out_flags,
    output logic              busy
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HAVE_A = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;
    localparam int LAT_W = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        HAVE_A = ST_HAVE_A,
        EXEC = ST_EXEC,
        HOLD = ST_HOLD
    } state_t;
    state_t state, next;
    logic [LAT_W-1:0] lat_cnt;
    logic accept, load_a, load_b, dec, capture;
    // Ready depends only on state, rst and flush, never on out_ready, so a
    // word offered during a flush cycle is simply not taken.
    assign in_ready = !rst && !flush && (state == EMPTY || state == HAVE_A);
    assign out_valid = state == HOLD;
    assign busy = state != EMPTY;
    always_comb begin
        accept = in_valid && in_ready;
        load_a = accept && state == EMPTY;
        load_b = accept && state == HAVE_A;
        dec = state == EXEC && lat_cnt != '0;
        capture = state == EXEC && lat_cnt == '0;
        next = state;
        if (flush) next = EMPTY;
        else if (load_a) next = HAVE_A;
        else if (load_b) next = EXEC;
        else if (capture) next = HOLD;
        else if (state == HOLD && out_ready) next = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= next;
    end
    // Operands and the last result survive a flush; only the pairing is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_cmd <= '0;
            lat_cnt <= '0;
            out_result <= '0;
            out_flags <= '0;
        end else if (!flush) begin
            if (load_a) alu_a <= in_data;
            if (load_b) begin
                alu_b <= in_data;
                alu_cmd <= in_cmd;
                lat_cnt <= LAT_W'(ALU_LAT);
            end
            if (dec) lat_cnt <= lat_cnt - LAT_W'(1);
            if (capture) begin
                out_result <= alu_r;
                out_flags[Z_BIT] <= alu_z;
                out_flags[CY_BIT] <= alu_cy;
            end
        end
    end
endmodule
